// File: rtl/pkg_ram.sv
// Shared RAM-path types: op codes, field widths and the arbiter state encoding.
package pkg_ram;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    RAM_OP_NONE  = 2'd0,
    RAM_OP_READ  = 2'd1,
    RAM_OP_WRITE = 2'd2
  } ram_op_t;

  typedef logic [1:0] ram_dtype_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  function automatic logic is_read(ram_op_t op);
    return op == RAM_OP_READ;
  endfunction
endpackage

// File: rtl/if_ram.sv
// RAM access bundle; the server side receives an op, the client side issues it.
interface if_ram;
  import pkg_ram::*;

  ram_op_t             op;
  ram_dtype_t          data_type;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   data_in;
  logic [DATA_W-1:0]   data_out;

  modport server (input op, data_type, addr, data_in, output data_out);
  modport client (output op, data_type, addr, data_in, input data_out);
endinterface

// File: rtl/arb_rr_pick.sv
// Combinational winner select: round-robin from ptr, or lowest index when PRIORITY_MODE=1.
module arb_rr_pick #(
  parameter int N             = 2,
  parameter int PRIORITY_MODE = 0,
  parameter int IDX_W         = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  always_comb begin
    int base;
    int cand;
    logic [IDX_W-1:0] cidx;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    base   = (PRIORITY_MODE != 0) ? 0 : int'(ptr);
    for (int k = 0; k < N; k++) begin
      cand = base + k;
      if (cand >= N) cand = cand - N;
      cidx = IDX_W'(cand);
      if (!any && req[cidx]) begin
        any          = 1'b1;
        idx          = cidx;
        onehot[cidx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dev_ram_arbiter.sv
// N-port arbiter in front of a single RAM: registered grant/done handshake,
// read-latency tracking and per-port read-data holding registers.
module dev_ram_arbiter
  import pkg_ram::*;
#(
  parameter int N_PORTS       = 2,
  parameter int RD_LATENCY    = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PORTS-1:0] req,
  output logic [N_PORTS-1:0] gnt,
  output logic [N_PORTS-1:0] done,
  if_ram.server              ramc [N_PORTS],
  if_ram.client              ram
);
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  arb_state_t          state_reg;
  logic [IDX_W-1:0]    sel_reg;
  logic [N_PORTS-1:0]  sel_oh_reg;
  logic [IDX_W-1:0]    rr_ptr_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [N_PORTS-1:0]  gnt_reg;
  logic [N_PORTS-1:0]  done_reg;
  ram_op_t             op_reg;
  ram_dtype_t          type_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   din_reg;

  ram_op_t             port_op   [N_PORTS];
  ram_dtype_t          port_type [N_PORTS];
  logic [ADDR_W-1:0]   port_addr [N_PORTS];
  logic [DATA_W-1:0]   port_din  [N_PORTS];

  logic [N_PORTS-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                capture;
  logic [IDX_W-1:0]    next_ptr;

  arb_rr_pick #(
    .N             (N_PORTS),
    .PRIORITY_MODE (PRIORITY_MODE),
    .IDX_W         (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign capture  = (state_reg == WAIT) && (cnt_reg == '0);
  assign next_ptr = (sel_reg == IDX_W'(N_PORTS - 1)) ? '0 : sel_reg + IDX_W'(1);

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    logic [DATA_W-1:0] dout_reg;

    assign port_op[gi]   = ramc[gi].op;
    assign port_type[gi] = ramc[gi].data_type;
    assign port_addr[gi] = ramc[gi].addr;
    assign port_din[gi]  = ramc[gi].data_in;
    assign ramc[gi].data_out = dout_reg;

    // Only a completing read of this port replaces the held value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_reg <= '0;
      end else if (capture && (sel_reg == IDX_W'(gi))) begin
        dout_reg <= ram.data_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sel_reg    <= '0;
      sel_oh_reg <= '0;
      rr_ptr_reg <= '0;
      cnt_reg    <= '0;
      gnt_reg    <= '0;
      done_reg   <= '0;
      op_reg     <= RAM_OP_NONE;
      type_reg   <= '0;
      addr_reg   <= '0;
      din_reg    <= '0;
    end else begin
      gnt_reg  <= '0;
      done_reg <= '0;
      op_reg   <= RAM_OP_NONE;
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            sel_reg    <= pick_idx;
            sel_oh_reg <= pick_onehot;
            gnt_reg    <= pick_onehot;
            op_reg     <= port_op[pick_idx];
            type_reg   <= port_type[pick_idx];
            addr_reg   <= port_addr[pick_idx];
            din_reg    <= port_din[pick_idx];
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          if (PRIORITY_MODE == 0) rr_ptr_reg <= next_ptr;
          if (is_read(op_reg)) begin
            cnt_reg   <= CNT_W'(RD_LATENCY - 1);
            state_reg <= WAIT;
          end else begin
            done_reg  <= sel_oh_reg;
            state_reg <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            done_reg  <= sel_oh_reg;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt            = gnt_reg;
  assign done           = done_reg;
  assign ram.op         = op_reg;
  assign ram.data_type  = type_reg;
  assign ram.addr       = addr_reg;
  assign ram.data_in    = din_reg;
endmodule

// File: tb/tb_dev_ram_arbiter.sv
// Bench: a round-robin and a fixed-priority arbiter share one client stimulus;
// each has its own RAM model, transaction-level reference and scoreboard monitor.
module tb_dev_ram_arbiter;
  import pkg_ram::*;

  localparam int N = 4;
  localparam int L = 2;

  typedef struct {
    int          port;
    int          cyc;
    ram_op_t     op;
    logic [1:0]  dtype;
    logic [15:0] addr;
    logic [31:0] din;
  } gnt_exp_t;

  typedef struct {
    int          port;
    int          cyc;
    logic [31:0] dout;
  } done_exp_t;

  logic        clk;
  logic        rst_n;
  logic [N-1:0] req;
  ram_op_t     cl_op   [N];
  logic [1:0]  cl_type [N];
  logic [15:0] cl_addr [N];
  logic [31:0] cl_din  [N];

  int cyc;
  int errors;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Reference arbitration rule: fixed = lowest set index; round-robin = first set
  // index at or after the port following the previous winner.
  function automatic int pick(logic [N-1:0] r, int last, int mode);
    int start;
    int p;
    start = (mode == 1) ? 0 : (last + 1) % N;
    for (int k = 0; k < N; k++) begin
      p = (start + k) % N;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int MODE = gi;

    if_ram        ramc_if [N] ();
    if_ram        ram_if ();
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic [31:0]  dout [N];

    for (genvar gp = 0; gp < N; gp++) begin : g_cl
      assign ramc_if[gp].op        = cl_op[gp];
      assign ramc_if[gp].data_type = cl_type[gp];
      assign ramc_if[gp].addr      = cl_addr[gp];
      assign ramc_if[gp].data_in   = cl_din[gp];
      assign dout[gp]              = ramc_if[gp].data_out;
    end

    dev_ram_arbiter #(
      .N_PORTS       (N),
      .RD_LATENCY    (L),
      .PRIORITY_MODE (MODE)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .gnt   (gnt),
      .done  (done),
      .ramc  (ramc_if),
      .ram   (ram_if)
    );

    // RAM device: read data valid exactly L cycles after the op cycle, poison otherwise.
    logic [31:0]  mem  [64];
    logic [L-1:0] rd_v;
    logic [31:0]  rd_d [L];
    initial begin
      for (int a = 0; a < 64; a++) mem[a] = init_word(a);
      rd_v = '0;
    end
    always @(posedge clk) begin
      if (ram_if.op == RAM_OP_WRITE) mem[ram_if.addr[5:0]] <= ram_if.data_in;
      rd_v[0] <= (ram_if.op == RAM_OP_READ);
      rd_d[0] <= mem[ram_if.addr[5:0]];
      for (int s = 1; s < L; s++) begin
        rd_v[s] <= rd_v[s-1];
        rd_d[s] <= rd_d[s-1];
      end
    end
    assign ram_if.data_out = rd_v[L-1] ? rd_d[L-1] : 32'hBAD0_BAD0;

    // Transaction-level reference: one transaction at a time, write 2 cycles, read L+2.
    gnt_exp_t    gq [$];
    done_exp_t   dq [$];
    logic [31:0] mem_m   [64];
    logic [31:0] exp_dout [N];
    int          free_cyc;
    int          last_w;
    initial for (int a = 0; a < 64; a++) mem_m[a] = init_word(a);

    always @(negedge clk) begin
      int w;
      gnt_exp_t  ge;
      done_exp_t de;
      if (!rst_n) begin
        gq.delete();
        dq.delete();
        free_cyc = 0;
        last_w   = N - 1;
        for (int p = 0; p < N; p++) exp_dout[p] = '0;
      end else if (cyc >= free_cyc && req != '0) begin
        w = pick(req, last_w, MODE);
        last_w   = w;
        ge.port  = w;
        ge.cyc   = cyc + 1;
        ge.op    = cl_op[w];
        ge.dtype = cl_type[w];
        ge.addr  = cl_addr[w];
        ge.din   = cl_din[w];
        gq.push_back(ge);
        if (cl_op[w] == RAM_OP_READ) begin
          exp_dout[w] = mem_m[cl_addr[w][5:0]];
          free_cyc    = cyc + L + 2;
        end else begin
          mem_m[cl_addr[w][5:0]] = cl_din[w];
          free_cyc    = cyc + 2;
        end
        de.port = w;
        de.cyc  = free_cyc;
        de.dout = exp_dout[w];
        dq.push_back(de);
      end
    end

    // Scoreboard monitor.
    logic [31:0] held [N];
    always @(negedge clk) begin
      gnt_exp_t  ge;
      done_exp_t de;
      bit        bad;
      if (!rst_n) begin
        bad = (gnt != '0) || (done != '0) || (ram_if.op != RAM_OP_NONE) ||
              (ram_if.addr != '0) || (ram_if.data_in != '0) || (ram_if.data_type != '0);
        for (int p = 0; p < N; p++) if (dout[p] != '0) bad = 1'b1;
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL reset_outputs inst%0d cyc=%0d: gnt=%b done=%b op=%0d addr=%h din=%h, required all zero",
                   gi, cyc, gnt, done, ram_if.op, ram_if.addr, ram_if.data_in);
        end
        for (int p = 0; p < N; p++) held[p] = '0;
      end else begin
        checks++;
        if (gnt != '0) begin
          if (gq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_gnt inst%0d cyc=%0d: gnt=%b, required none", gi, cyc, gnt);
          end else begin
            ge = gq.pop_front();
            if (gnt !== (N'(1) << ge.port) || cyc != ge.cyc || ram_if.op !== ge.op ||
                ram_if.addr !== ge.addr || ram_if.data_in !== ge.din || ram_if.data_type !== ge.dtype) begin
              errors++;
              $display("FAIL gnt inst%0d: got gnt=%b@%0d op=%0d addr=%h din=%h type=%0d, required gnt=%b@%0d op=%0d addr=%h din=%h type=%0d",
                       gi, gnt, cyc, ram_if.op, ram_if.addr, ram_if.data_in, ram_if.data_type,
                       N'(1) << ge.port, ge.cyc, ge.op, ge.addr, ge.din, ge.dtype);
            end
          end
        end else if (ram_if.op !== RAM_OP_NONE) begin
          errors++;
          $display("FAIL op_outside_issue inst%0d cyc=%0d: op=%0d, required NONE", gi, cyc, ram_if.op);
        end
        if (gq.size() != 0 && gq[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_gnt inst%0d cyc=%0d: no gnt, required gnt[%0d]@%0d", gi, cyc, gq[0].port, gq[0].cyc);
          void'(gq.pop_front());
        end

        if (done != '0) begin
          checks++;
          if (dq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done inst%0d cyc=%0d: done=%b, required none", gi, cyc, done);
          end else begin
            de = dq.pop_front();
            held[de.port] = de.dout;
            if (done !== (N'(1) << de.port) || cyc != de.cyc) begin
              errors++;
              $display("FAIL done inst%0d: got done=%b@%0d, required done=%b@%0d",
                       gi, done, cyc, N'(1) << de.port, de.cyc);
            end
            checks++;
            if (dout[de.port] !== de.dout) begin
              errors++;
              $display("FAIL read_data inst%0d port%0d cyc=%0d: got %h, required %h",
                       gi, de.port, cyc, dout[de.port], de.dout);
            end
            $display("inst%0d port%0d done cyc=%0d data_out=%h", gi, de.port, cyc, dout[de.port]);
          end
        end
        if (dq.size() != 0 && dq[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_done inst%0d cyc=%0d: no done, required done[%0d]@%0d", gi, cyc, dq[0].port, dq[0].cyc);
          held[dq[0].port] = dq[0].dout;
          void'(dq.pop_front());
        end

        bad = 1'b0;
        for (int p = 0; p < N; p++) if (dout[p] !== held[p]) bad = 1'b1;
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL hold inst%0d cyc=%0d: got %h %h %h %h, required %h %h %h %h", gi, cyc,
                   dout[0], dout[1], dout[2], dout[3], held[0], held[1], held[2], held[3]);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_port(int p, logic on, ram_op_t op, logic [15:0] a, logic [31:0] d);
    req[p] = on;
    if (on) begin
      cl_op[p]   = op;
      cl_addr[p] = a;
      cl_din[p]  = d;
      cl_type[p] = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    int left [N];
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    req    = '0;
    for (int p = 0; p < N; p++) begin
      cl_op[p]   = RAM_OP_NONE;
      cl_type[p] = '0;
      cl_addr[p] = '0;
      cl_din[p]  = '0;
      left[p]    = 0;
    end
    step(3);
    rst_n = 1'b1;

    // Single write from port 0.
    set_port(0, 1'b1, RAM_OP_WRITE, 16'h10, 32'h0000_00AB);
    step(2);
    set_port(0, 1'b0, RAM_OP_NONE, '0, '0);
    step(4);

    // Port 1 writes then reads back 0x1234 at 0x20.
    set_port(1, 1'b1, RAM_OP_WRITE, 16'h20, 32'h0000_1234);
    step(2);
    set_port(1, 1'b0, RAM_OP_NONE, '0, '0);
    step(1);
    set_port(1, 1'b1, RAM_OP_READ, 16'h20, 32'h0);
    step(2);
    set_port(1, 1'b0, RAM_OP_NONE, '0, '0);
    step(6);

    // All four ports held.
    for (int p = 0; p < N; p++)
      set_port(p, 1'b1, (p % 2 == 0) ? RAM_OP_WRITE : RAM_OP_READ, 16'(16'h30 + p), $urandom);
    step(40);
    req = '0;
    step(8);

    // req = 1010 held, then port 1 drops out.
    set_port(1, 1'b1, RAM_OP_READ, 16'h20, 32'h0);
    set_port(3, 1'b1, RAM_OP_WRITE, 16'h33, 32'h5A5A_0033);
    step(30);
    set_port(1, 1'b0, RAM_OP_NONE, '0, '0);
    step(12);
    req = '0;
    step(8);

    // Reset while a port-2 read is waiting for data.
    set_port(2, 1'b1, RAM_OP_READ, 16'h31, 32'h0);
    step(2);
    set_port(2, 1'b0, RAM_OP_NONE, '0, '0);
    #2;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    set_port(1, 1'b1, RAM_OP_WRITE, 16'h21, 32'h0BAD_CAFE);
    step(2);
    set_port(1, 1'b0, RAM_OP_NONE, '0, '0);
    step(6);

    // Port 0 read with req dropped one cycle after its grant.
    set_port(0, 1'b1, RAM_OP_READ, 16'h10, 32'h0);
    step(2);
    set_port(0, 1'b0, RAM_OP_NONE, '0, '0);
    step(8);

    // Random request phases; fields change only when a request starts.
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < N; p++) begin
        if (left[p] == 0) begin
          if (req[p]) begin
            req[p]  = 1'b0;
            left[p] = $urandom_range(1, 4);
          end else begin
            set_port(p, 1'b1, ($urandom_range(0, 1) == 1) ? RAM_OP_READ : RAM_OP_WRITE,
                     16'($urandom_range(0, 63)), $urandom);
            left[p] = $urandom_range(1, 15);
          end
        end else begin
          left[p] = left[p] - 1;
        end
      end
      step(1);
    end

    req = '0;
    step(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dev_ram_arbiter.md
Name: dev_ram_arbiter

Overview:
- N-port RAM arbiter for the ULM memory path. Successor to the two-way combinational RAM switch: same if_ram server/client roles, but generalised to N_PORTS clients.
- Adds a registered request/grant/done handshake, round-robin or fixed-priority arbitration, read-latency tracking and per-port read-data holding registers.
- Sits between the CPU, loader, debug and DMA masters and the single if_ram RAM device.

Parameters:
- N_PORTS, 2: number of client ports (2..8).
- RD_LATENCY, 1: cycles from the op cycle to valid ram.data_out (1..4).
- PRIORITY_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_PORTS  per-client request. The client holds its if_ram fields stable while req is high.
- gnt  output  N_PORTS  one-cycle pulse: the client's op is on the RAM this cycle.
- done  output  N_PORTS  one-cycle pulse: transaction complete; read data valid on that client's data_out.
- ramc[N_PORTS]  if_ram.server  —  client ports (op, data_type, addr, data_in in; data_out out). Widths come from pkg_ram.
- ram  if_ram.client  —  toward the RAM device.

Behaviour:
- Reset (async assert, sync release): state IDLE; gnt = 0; done = 0; all ramc[i].data_out = 0; rr_ptr = 0; ram.op = RAM_OP_NONE; ram.addr, ram.data_in, ram.data_type = 0.
- State IDLE:
  - If any req bit is set, pick winner w and latch sel = w.
  - Go to ISSUE next cycle; otherwise stay in IDLE.
- Arbitration:
  - Round-robin: first set req bit at or after rr_ptr, scanning with wrap-around modulo N_PORTS.
  - Fixed priority: lowest set index.
- State ISSUE:
  - ram fields = ramc[sel] fields; gnt[sel] = 1.
  - Round-robin only: rr_ptr <= (sel+1) mod N_PORTS.
  - Write op: go to IDLE, with done[sel] = 1 in the next cycle.
  - Read op: go to WAIT, cnt = RD_LATENCY-1.
- State WAIT:
  - ram.op = RAM_OP_NONE; other ram fields hold their ISSUE values.
  - When cnt == 0: capture ram.data_out into ramc[sel].data_out, go to IDLE, done[sel] = 1 next cycle.
  - Otherwise cnt decrements.
- Outside ISSUE, ram.op is always RAM_OP_NONE.
- done pulse and updated data_out appear in the same cycle the FSM is back in IDLE. IDLE arbitrates in that same cycle.
- Throughput: write = 2 cycles per transaction; read = RD_LATENCY+2 cycles.
- Read-data holding: each ramc[i].data_out is registered and holds its last read value until that port's next read completes. Writes do not alter it.
- Request dropped after gnt: the transaction still completes and done still pulses. Request dropped before gnt: nothing is issued.
- N_PORTS = 1: always grants port 0; rr_ptr stays 0.
- Reset mid-WAIT: transaction abandoned, no done pulse, data_out cleared.
- Simultaneous requests in round-robin mode: no port is granted twice while another port holds continuous req.
- Starvation bound (round-robin): a held req is granted within N_PORTS transactions.

Decomposition:
- Add to pkg_ram:
  - RAM_OP_NONE constant.
  - is_read(op) function.
  - arb_state_t enum {IDLE, ISSUE, WAIT}.
- One natural sub-module: arb_rr_pick.
  - Combinational winner select from req, rr_ptr and PRIORITY_MODE.
  - Outputs a one-hot vector plus index and any-bit.
  - Reusable for future bus arbiters.

Test Plan:
- Reset, then port0 write addr=0x10 data=0xAB: gnt[0] in cycle 1, ram.op = write in the same cycle, done[0] in cycle 2; ram.op = NONE in cycles 0 and 2.
- RD_LATENCY=2, port1 read addr=0x20 with RAM returning 0x1234: gnt[1] at t, done[1] at t+3, ramc[1].data_out = 0x1234 from t+3, ramc[0].data_out unchanged.
- N_PORTS=4, round-robin, all req held: grant order 0,1,2,3,0,1; no gnt for a port whose req is low.
- PRIORITY_MODE=1, req = 4'b1010 held: port1 granted every transaction; port3 granted only after req[1] drops.
- Async rst_n low during WAIT: all outputs zero immediately; no done after release; next req gets gnt 2 cycles after IDLE entry.
- Port0 drops req one cycle after its gnt on a read: done[0] still pulses and data is captured.
